// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage for the 16-bit CPU. It owns the fetch PC and issues one
//   outstanding instruction-memory request at a time. Returned words are
//   queued together with their byte address. A redirect flushes the queue
//   and restarts fetch at the new address.
//
// Ports
//   Clock, Reset            : single clock, synchronous active-high reset
//   IMemReq/IMemAddr        : registered request and even byte address
//   IMemAck/IMemData        : completion strobe and instruction word
//   InstrValid/InstrReady   : queue head handshake toward the datapath
//   Instruction/InstrPC     : queue head word and its byte address (zero when invalid)
//   Redirect/RedirectPC     : flush and restart at RedirectPC (bit 0 forced to 0)
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int unsigned QUEUE_DEPTH = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   output logic        IMemReq,
   output logic [15:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [15:0] IMemData,
   output logic        InstrValid,
   input  logic        InstrReady,
   output logic [15:0] Instruction,
   output logic [15:0] InstrPC,
   input  logic        Redirect,
   input  logic [15:0] RedirectPC
);

   localparam int unsigned    PW         = $clog2(QUEUE_DEPTH);
   localparam int unsigned    CW         = PW + 1;
   localparam logic [15:0]    RESET_PC_E = RESET_PC & 16'hFFFE;
   localparam logic [CW-1:0]  DEPTH_C    = CW'(QUEUE_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

   state_e          state_q, state_d;
   logic            req_q, req_d;
   logic [15:0]     addr_q, addr_d;
   logic [15:0]     fpc_q, fpc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [15:0]     q_instr_q [QUEUE_DEPTH];
   logic [15:0]     q_pc_q    [QUEUE_DEPTH];
   logic            push, pop;
   logic [15:0]     redir_pc;
   logic [15:0]     fpc_inc;

   assign redir_pc = RedirectPC & 16'hFFFE;
   assign fpc_inc  = fpc_q + 16'd2;

   // Head is read straight from queue registers: no path from IMemData.
   assign InstrValid  = (count_q != '0);
   assign Instruction = InstrValid ? q_instr_q[rd_ptr_q] : '0;
   assign InstrPC     = InstrValid ? q_pc_q[rd_ptr_q]    : '0;
   assign IMemReq     = req_q;
   assign IMemAddr    = addr_q;

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      addr_d   = addr_q;
      fpc_d    = fpc_q;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      push     = 1'b0;
      pop      = 1'b0;

      if (Redirect) begin
         // Flush wins over any same-cycle push or pop.
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         fpc_d    = redir_pc;
         if (state_q == IDLE || IMemAck) begin
            state_d = REQ;
            req_d   = 1'b1;
            addr_d  = redir_pc;
         end else begin
            // Request still in flight: keep it stable and discard its data later.
            state_d = DRAIN;
         end
      end else begin
         push     = (state_q == REQ) && IMemAck;
         pop      = InstrValid && InstrReady;
         count_d  = count_q + CW'(push) - CW'(pop);
         rd_ptr_d = rd_ptr_q + PW'(pop);
         wr_ptr_d = wr_ptr_q + PW'(push);
         unique case (state_q)
            IDLE: begin
               if (count_d < DEPTH_C) begin
                  state_d = REQ;
                  req_d   = 1'b1;
                  addr_d  = fpc_q;
               end
            end
            REQ: begin
               if (IMemAck) begin
                  fpc_d = fpc_inc;
                  if (count_d < DEPTH_C) begin
                     addr_d = fpc_inc;
                  end else begin
                     state_d = IDLE;
                     req_d   = 1'b0;
                  end
               end
            end
            DRAIN: begin
               if (IMemAck) begin
                  state_d = REQ;
                  addr_d  = fpc_q;
               end
            end
            default: begin
               state_d = IDLE;
               req_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         addr_q   <= RESET_PC_E;
         fpc_q    <= RESET_PC_E;
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         addr_q   <= addr_d;
         fpc_q    <= fpc_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Queue storage needs no reset; occupancy is tracked by count_q.
   always_ff @(posedge Clock) begin
      if (!Reset && push) begin
         q_instr_q[wr_ptr_q] <= IMemData;
         q_pc_q[wr_ptr_q]    <= addr_q;
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit with a behavioural instruction
//   memory (configurable ack delay) and a scoreboard of expected queue
//   entries in fetch order.
module tb_instr_fetch_unit;

   localparam int unsigned DEPTH = 2;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        IMemReq;
   logic [15:0] IMemAddr;
   logic        IMemAck;
   logic [15:0] IMemData;
   logic        InstrValid;
   logic        InstrReady;
   logic [15:0] Instruction;
   logic [15:0] InstrPC;
   logic        Redirect;
   logic [15:0] RedirectPC;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
   } entry_t;

   entry_t      sb[$];
   int          errors = 0;
   int          checks = 0;
   int          wait_cnt = 0;
   int          ack_delay = 0;
   int          ack_cnt = 0;
   bit          stale = 1'b0;
   bit          hold_addr_chk = 1'b0;
   logic [15:0] prev_addr = 16'h0000;

   instr_fetch_unit #(
      .RESET_PC    (16'h0000),
      .QUEUE_DEPTH (DEPTH)
   ) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .IMemReq     (IMemReq),
      .IMemAddr    (IMemAddr),
      .IMemAck     (IMemAck),
      .IMemData    (IMemData),
      .InstrValid  (InstrValid),
      .InstrReady  (InstrReady),
      .Instruction (Instruction),
      .InstrPC     (InstrPC),
      .Redirect    (Redirect),
      .RedirectPC  (RedirectPC)
   );

   always #5 Clock = ~Clock;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1);
   end

   function automatic logic [15:0] memword(input logic [15:0] a);
      return (a * 16'd3) ^ 16'h5A3C;
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: called at a falling edge, checks the registered
   // outputs, drives memory response, updates the scoreboard, advances.
   task automatic step();
      logic ack;
      entry_t e;
      ack      = IMemReq && (wait_cnt >= ack_delay);
      IMemAck  = ack;
      IMemData = ack ? memword(IMemAddr) : 16'hBAD1;

      if (hold_addr_chk) chk("addr_stable", IMemAddr, prev_addr);
      chk("addr_even", {15'd0, IMemAddr[0]}, 16'd0);
      chk("valid", {15'd0, InstrValid}, {15'd0, sb.size() != 0});
      if (InstrValid && sb.size() != 0) begin
         chk("head_instr", Instruction, sb[0].instr);
         chk("head_pc", InstrPC, sb[0].pc);
      end else if (!InstrValid) begin
         chk("instr_zero", Instruction, 16'h0000);
      end

      hold_addr_chk = !Reset && IMemReq && !ack;
      prev_addr     = IMemAddr;
      if (ack && !Reset) ack_cnt++;

      if (Reset) begin
         sb.delete();
         stale = 1'b0;
      end else if (Redirect) begin
         sb.delete();
         stale = IMemReq && !ack;
      end else begin
         if (InstrValid && InstrReady && sb.size() != 0) void'(sb.pop_front());
         if (ack) begin
            if (stale) stale = 1'b0;
            else begin
               e.instr = memword(IMemAddr);
               e.pc    = IMemAddr;
               sb.push_back(e);
            end
         end
      end

      if (Reset || !IMemReq || ack) wait_cnt = 0;
      else wait_cnt++;

      @(negedge Clock);
      Redirect = 1'b0;
   endtask

   initial begin
      Reset      = 1'b1;
      InstrReady = 1'b1;
      Redirect   = 1'b0;
      RedirectPC = 16'h0000;
      IMemAck    = 1'b0;
      IMemData   = 16'h0000;
      repeat (2) @(negedge Clock);

      // Reset values
      chk("rst_req", {15'd0, IMemReq}, 16'd0);
      chk("rst_addr", IMemAddr, 16'h0000);
      chk("rst_valid", {15'd0, InstrValid}, 16'd0);
      chk("rst_instr", Instruction, 16'h0000);
      chk("rst_pc", InstrPC, 16'h0000);

      // Zero-wait streaming
      Reset = 1'b0;
      step();
      chk("first_req", {15'd0, IMemReq}, 16'd1);
      chk("first_addr", IMemAddr, 16'h0000);
      step();
      chk("stream_addr1", IMemAddr, 16'h0002);
      chk("stream_valid", {15'd0, InstrValid}, 16'd1);
      chk("stream_pc0", InstrPC, 16'h0000);
      step();
      chk("stream_addr2", IMemAddr, 16'h0004);
      chk("stream_pc1", InstrPC, 16'h0002);

      // Ready held low: fill the queue, then drain
      Reset = 1'b1;
      step();
      Reset      = 1'b0;
      InstrReady = 1'b0;
      ack_cnt    = 0;
      repeat (8) step();
      chk("full_acks", 16'(ack_cnt), 16'(DEPTH));
      chk("full_req", {15'd0, IMemReq}, 16'd0);
      InstrReady = 1'b1;
      step();
      chk("refill_req", {15'd0, IMemReq}, 16'd1);
      chk("refill_addr", IMemAddr, 16'h0004);
      repeat (3) step();

      // Memory ack delayed 3 cycles
      Reset = 1'b1;
      step();
      Reset     = 1'b0;
      ack_delay = 3;
      step();
      for (int i = 0; i < 4; i++) begin
         chk("slow_req", {15'd0, IMemReq}, 16'd1);
         chk("slow_addr", IMemAddr, 16'h0000);
         step();
      end
      chk("slow_valid", {15'd0, InstrValid}, 16'd1);
      chk("slow_instr", Instruction, memword(16'h0000));

      // Redirect while a request is outstanding
      step();
      Redirect   = 1'b1;
      RedirectPC = 16'h0041;
      step();
      chk("drain_empty", {15'd0, InstrValid}, 16'd0);
      chk("drain_req", {15'd0, IMemReq}, 16'd1);
      chk("drain_addr", IMemAddr, 16'h0002);
      step();
      step();
      chk("drain_done_addr", IMemAddr, 16'h0040);
      chk("drain_no_stale", {15'd0, InstrValid}, 16'd0);
      ack_delay = 0;
      step();
      chk("redir_valid", {15'd0, InstrValid}, 16'd1);
      chk("redir_pc", InstrPC, 16'h0040);

      // Redirect coincident with ack and pop
      step();
      Redirect   = 1'b1;
      RedirectPC = 16'h0100;
      step();
      chk("coinc_empty", {15'd0, InstrValid}, 16'd0);
      chk("coinc_addr", IMemAddr, 16'h0100);
      step();
      chk("coinc_pc", InstrPC, 16'h0100);

      // PC wrap
      Redirect   = 1'b1;
      RedirectPC = 16'hFFFE;
      step();
      chk("wrap_addr0", IMemAddr, 16'hFFFE);
      step();
      chk("wrap_addr1", IMemAddr, 16'h0000);
      chk("wrap_pc0", InstrPC, 16'hFFFE);
      step();
      chk("wrap_pc1", InstrPC, 16'h0000);

      // Reset in the middle of a request
      ack_delay = 5;
      step();
      chk("mid_req", {15'd0, IMemReq}, 16'd1);
      Reset = 1'b1;
      step();
      chk("mid_rst_req", {15'd0, IMemReq}, 16'd0);
      chk("mid_rst_addr", IMemAddr, 16'h0000);
      chk("mid_rst_valid", {15'd0, InstrValid}, 16'd0);
      chk("mid_rst_instr", Instruction, 16'h0000);
      chk("mid_rst_pc", InstrPC, 16'h0000);
      Reset     = 1'b0;
      ack_delay = 0;
      repeat (4) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
